// File: rtl/panda_dmem_responder.sv
// Data-memory responder for the Panda LSU port: accepts one req/gnt request at a time,
// holds it for LATENCY cycles, then performs the word access and pulses rvalid.
module panda_dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int IDX_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("panda_dmem_responder: DEPTH must be a power of two and at least 2");
  end
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("panda_dmem_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [3:0]  be_q;
  logic [29:0] idx_q;
  logic [31:0] wdata_q;
  logic        accept;
  logic        in_range;

  logic [31:0] mem [DEPTH];

  // Byte offset within the word plays no part in a word-wide access.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  assign in_range    = (idx_q >> IDX_W) == 30'd0;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_o    = 1'b0;
    accept   = 1'b0;
    rvalid_o = 1'b0;
    rdata_o  = 32'd0;
    err_o    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        gnt_o  = req_i;
        accept = req_i;
        if (req_i) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        rvalid_o = 1'b1;
        state_d  = S_IDLE;
        if (!in_range) begin
          err_o = 1'b1;
        end else if (!we_q) begin
          rdata_o = mem[idx_q[IDX_W-1:0]];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      idx_q   <= 30'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we_i;
        be_q    <= be_i;
        idx_q   <= addr_i[31:2];
        wdata_q <= wdata_i;
      end
    end
  end

  // Array has no reset; an aborted store never reaches RESP, so it never writes.
  always_ff @(posedge clk_i) begin
    if (state_q == S_RESP && we_q && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[idx_q[IDX_W-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_panda_dmem_responder.sv
// Bench for panda_dmem_responder: three instances (LATENCY 1, 4, 3) driven by directed
// transactions; a scoreboard queue holds {cycle, instance, err, rdata} per expected response.
module tb_panda_dmem_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n  [N];
  logic        req    [N];
  logic        we     [N];
  logic [3:0]  be     [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic        gnt    [N];
  logic        rvalid [N];
  logic [31:0] rdata  [N];
  logic        err    [N];
  logic [1:0]  state  [N];

  logic [15:0] cyc = 16'd0;
  int n_checks = 0;
  int n_err    = 0;

  // Entry layout: [50:35] response cycle, [34:33] instance, [32] err, [31:0] rdata.
  logic [50:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    panda_dmem_responder #(
      .DEPTH  (1024),
      .LATENCY(gi == 0 ? 1 : (gi == 1 ? 4 : 3))
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n[gi]),
      .req_i      (req[gi]),
      .we_i       (we[gi]),
      .be_i       (be[gi]),
      .addr_i     (addr[gi]),
      .wdata_i    (wdata[gi]),
      .gnt_o      (gnt[gi]),
      .rvalid_o   (rvalid[gi]),
      .rdata_o    (rdata[gi]),
      .err_o      (err[gi]),
      .dbg_state_o(state[gi])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rvalid[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_rvalid: inst %0d actual=1 required=0 (cycle %0d)", i, cyc);
        end else begin
          logic [50:0] e;
          e = exp_q.pop_front();
          check("resp_inst",  32'(i),       32'(e[34:33]));
          check("resp_cycle", 32'(cyc),     32'(e[50:35]));
          check("resp_err",   32'(err[i]),  32'(e[32]));
          check("resp_rdata", rdata[i],     e[31:0]);
        end
      end else if (rvalid[i] === 1'b0 && (rdata[i] !== 32'd0 || err[i] !== 1'b0)) begin
        check("idle_outputs", {rdata[i][30:0], err[i]}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain();
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_txn(input int i, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int wait_k;
    wait_k = -1;
    @(posedge clk); #1;
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt[i] === 1'b1) begin
        wait_k = k;
        exp_q.push_back({cyc + 16'(lat_of(i)), 2'(i), exp_err, exp_rdata});
        break;
      end
      @(posedge clk); #1;
    end
    check("gnt_in_req_cycle", 32'(wait_k), 32'd0);
    @(posedge clk); #1;
    // Request fields change after the grant; the DUT must use the latched copy.
    req[i] = 1'b0; we[i] = 1'($urandom_range(0, 1)); be[i] = 4'($urandom_range(0, 15));
    addr[i] = $urandom; wdata[i] = $urandom;
    wait_drain();
  endtask

  task automatic hold_burst(input int i, input int n, input int period,
                            input logic [31:0] a, input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    req[i] = 1'b1; we[i] = 1'b0; be[i] = 4'hF; addr[i] = a; wdata[i] = 32'd0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("burst_gnt", 32'(gnt[i]), 32'((k % period) == 0));
      if (gnt[i] === 1'b1) exp_q.push_back({cyc + 16'(lat_of(i)), 2'(i), 1'b0, exp_rdata});
      @(posedge clk); #1;
    end
    req[i] = 1'b0;
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'd0;
      addr[i] = 32'd0; wdata[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("rst_state",  32'(state[i]),  32'd0);
      check("rst_rvalid", 32'(rvalid[i]), 32'd0);
      check("rst_rdata",  rdata[i],       32'd0);
      check("rst_err",    32'(err[i]),    32'd0);
      check("rst_gnt",    32'(gnt[i]),    32'd0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;

    // LATENCY=1: basic store/load
    do_txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_txn(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte-enable merge and be=0 store
    do_txn(0, 1'b1, 4'hF,    32'h20, 32'h11223344, 32'h0, 1'b0);
    do_txn(0, 1'b1, 4'b0100, 32'h20, 32'h00AA0000, 32'h0, 1'b0);
    do_txn(0, 1'b0, 4'hF,    32'h20, 32'h0, 32'h11AA3344, 1'b0);
    do_txn(0, 1'b1, 4'h0,    32'h20, 32'hFFFFFFFF, 32'h0, 1'b0);
    do_txn(0, 1'b0, 4'hF,    32'h20, 32'h0, 32'h11AA3344, 1'b0);

    // Outer byte lanes; low address bits ignored
    do_txn(0, 1'b1, 4'hF,    32'h30, 32'h00000000, 32'h0, 1'b0);
    do_txn(0, 1'b1, 4'b0001, 32'h30, 32'h000000EE, 32'h0, 1'b0);
    do_txn(0, 1'b1, 4'b1000, 32'h30, 32'h77000000, 32'h0, 1'b0);
    do_txn(0, 1'b0, 4'hF,    32'h33, 32'h0, 32'h770000EE, 1'b0);

    // Out of range and top-of-array boundary
    do_txn(0, 1'b1, 4'hF, 32'h0,        32'hA5A55A5A, 32'h0, 1'b0);
    do_txn(0, 1'b0, 4'hF, 32'h1000,     32'h0,        32'h0, 1'b1);
    do_txn(0, 1'b1, 4'hF, 32'h1000,     32'hFFFFFFFF, 32'h0, 1'b1);
    do_txn(0, 1'b0, 4'hF, 32'h0,        32'h0, 32'hA5A55A5A, 1'b0);
    do_txn(0, 1'b1, 4'hF, 32'hFFC,      32'h01020304, 32'h0, 1'b0);
    do_txn(0, 1'b0, 4'hF, 32'hFFC,      32'h0, 32'h01020304, 1'b0);
    do_txn(0, 1'b0, 4'hF, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);

    // Back-to-back with req held: grants every other cycle, 5 responses
    hold_burst(0, 10, 2, 32'h10, 32'hDEADBEEF);

    // LATENCY=4: grant at T, rvalid at T+4, next grant at T+5
    do_txn(1, 1'b1, 4'hF, 32'h8, 32'h0BADCAFE, 32'h0, 1'b0);
    hold_burst(1, 6, 5, 32'h8, 32'h0BADCAFE);

    // LATENCY=3: reset during WAIT discards the pending store
    do_txn(2, 1'b1, 4'hF, 32'h40, 32'h12345678, 32'h0, 1'b0);
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h40; wdata[2] = 32'hCAFEF00D;
    @(negedge clk);
    check("abort_gnt", 32'(gnt[2]), 32'd1);
    @(posedge clk); #1;
    req[2] = 1'b0;
    check("abort_in_wait", 32'(state[2]), 32'd1);
    rst_n[2] = 1'b0;
    #1;
    check("abort_state",  32'(state[2]),  32'd0);
    check("abort_rvalid", 32'(rvalid[2]), 32'd0);
    check("abort_rdata",  rdata[2],       32'd0);
    check("abort_err",    32'(err[2]),    32'd0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_pending", 32'(exp_q.size()), 32'd0);
    do_txn(2, 1'b0, 4'hF, 32'h40, 32'h0, 32'h12345678, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
